// File: rtl/div_iter_exec_unit_if.sv
// rtl/div_iter_exec_unit_if.sv - issue and CDB handshake bundle for the iterative divider
interface div_iter_exec_unit_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 6
);
    logic             issue_valid;
    logic [1:0]       issue_op;
    logic [XLEN-1:0]  issue_rs_data;
    logic [XLEN-1:0]  issue_rt_data;
    logic [TAG_W-1:0] issue_rd_tag;
    logic             flush;
    logic             cdb_grant;
    logic             div_exec_unit_busy;
    logic             cdb_valid;
    logic [XLEN-1:0]  cdb_data;
    logic [TAG_W-1:0] cdb_tag;
    logic             cdb_branch;
    logic             cdb_branch_taken;

    modport master (
        output issue_valid, issue_op, issue_rs_data, issue_rt_data, issue_rd_tag,
        output flush, cdb_grant,
        input  div_exec_unit_busy, cdb_valid, cdb_data, cdb_tag, cdb_branch, cdb_branch_taken
    );

    modport slave (
        input  issue_valid, issue_op, issue_rs_data, issue_rt_data, issue_rd_tag,
        input  flush, cdb_grant,
        output div_exec_unit_busy, cdb_valid, cdb_data, cdb_tag, cdb_branch, cdb_branch_taken
    );
endinterface

// File: rtl/div_iter_exec_unit.sv
// rtl/div_iter_exec_unit.sv - radix-2 restoring DIV/DIVU/REM/REMU unit with CDB hold and flush
module div_iter_exec_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 6
) (
    input logic               clk,
    input logic               rst,
    div_iter_exec_unit_if.slave bus
);
    localparam int CW = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [XLEN-1:0]  rem;
    logic [XLEN-1:0]  quo;
    logic [XLEN-1:0]  div_mag;
    logic             op_rem;
    logic             op_signed;
    logic             sign_a;
    logic             sign_b;
    logic             busy_q;
    logic             valid_q;
    logic [XLEN-1:0]  data_q;
    logic [TAG_W-1:0] tag_q;

    logic             in_signed;
    logic [XLEN-1:0]  a_mag_in;
    logic [XLEN-1:0]  b_mag_in;
    logic             special_hit;
    logic [XLEN-1:0]  special_data;
    logic [XLEN:0]    shifted;
    logic [XLEN:0]    trial;
    logic [XLEN-1:0]  next_rem;
    logic [XLEN-1:0]  next_quo;
    logic [XLEN-1:0]  q_fix;
    logic [XLEN-1:0]  r_fix;

    always_comb begin
        in_signed    = ~bus.issue_op[0];
        a_mag_in     = (in_signed && bus.issue_rs_data[XLEN-1]) ? -bus.issue_rs_data : bus.issue_rs_data;
        b_mag_in     = (in_signed && bus.issue_rt_data[XLEN-1]) ? -bus.issue_rt_data : bus.issue_rt_data;
        special_hit  = 1'b0;
        special_data = '0;
        if (bus.issue_rt_data == '0) begin
            special_hit  = 1'b1;
            special_data = bus.issue_op[1] ? bus.issue_rs_data : '1;
        end else if (in_signed && bus.issue_rs_data == MIN_VAL && bus.issue_rt_data == '1) begin
            special_hit  = 1'b1;
            special_data = bus.issue_op[1] ? '0 : bus.issue_rs_data;
        end
    end

    // One restoring step: a borrow out of the XLEN+1-bit subtract means the trial failed.
    always_comb begin
        shifted  = {rem, quo[XLEN-1]};
        trial    = shifted - {1'b0, div_mag};
        next_rem = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
        next_quo = {quo[XLEN-2:0], ~trial[XLEN]};
        q_fix    = (op_signed && (sign_a ^ sign_b)) ? -next_quo : next_quo;
        r_fix    = (op_signed && sign_a) ? -next_rem : next_rem;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            rem       <= '0;
            quo       <= '0;
            div_mag   <= '0;
            op_rem    <= 1'b0;
            op_signed <= 1'b0;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            tag_q     <= '0;
        end else if (bus.flush) begin
            state   <= IDLE;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.issue_valid) begin
                        op_rem    <= bus.issue_op[1];
                        op_signed <= in_signed;
                        sign_a    <= in_signed & bus.issue_rs_data[XLEN-1];
                        sign_b    <= in_signed & bus.issue_rt_data[XLEN-1];
                        tag_q     <= bus.issue_rd_tag;
                        busy_q    <= 1'b1;
                        if (special_hit) begin
                            data_q  <= special_data;
                            valid_q <= 1'b1;
                            state   <= DONE;
                        end else begin
                            rem     <= '0;
                            quo     <= a_mag_in;
                            div_mag <= b_mag_in;
                            count   <= CW'(XLEN);
                            state   <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem   <= next_rem;
                    quo   <= next_quo;
                    count <= count - CW'(1);
                    if (count == CW'(1)) begin
                        data_q  <= op_rem ? r_fix : q_fix;
                        valid_q <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (bus.cdb_grant) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.div_exec_unit_busy = busy_q;
    assign bus.cdb_valid          = valid_q;
    assign bus.cdb_data           = data_q;
    assign bus.cdb_tag            = tag_q;
    assign bus.cdb_branch         = 1'b0;
    assign bus.cdb_branch_taken   = 1'b0;
endmodule

// File: tb/tb_div_iter_exec_unit.sv
// tb/tb_div_iter_exec_unit.sv - self-checking bench for div_iter_exec_unit
module tb_div_iter_exec_unit;
    localparam int XLEN  = 32;
    localparam int TAG_W = 6;
    localparam logic [XLEN-1:0] MIN_VAL = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    div_iter_exec_unit_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus_if ();

    div_iter_exec_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    typedef struct {
        logic [1:0]       op;
        logic [XLEN-1:0]  a;
        logic [XLEN-1:0]  b;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  exp_data;
        int               exp_lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: RISC-V divide semantics from plain arithmetic; bit XLEN flags a 1-cycle special.
    function automatic logic [XLEN:0] ref_div(input logic [1:0] op, input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
        logic signed [XLEN-1:0] sa, sb;
        sa = a;
        sb = b;
        if (b == 0)
            return {1'b1, (op[1] ? a : {XLEN{1'b1}})};
        if (!op[0] && a == MIN_VAL && b == {XLEN{1'b1}})
            return {1'b1, (op[1] ? {XLEN{1'b0}} : a)};
        case (op)
            2'b00:   return {1'b0, XLEN'(sa / sb)};
            2'b01:   return {1'b0, a / b};
            2'b10:   return {1'b0, XLEN'(sa % sb)};
            default: return {1'b0, a % b};
        endcase
    endfunction

    task automatic accept(input logic [1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input logic [TAG_W-1:0] tag);
        bus_if.issue_op      = op;
        bus_if.issue_rs_data = a;
        bus_if.issue_rt_data = b;
        bus_if.issue_rd_tag  = tag;
        bus_if.issue_valid   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus_if.issue_valid   = 1'b0;
    endtask

    task automatic wait_result(output int lat);
        lat = 1;
        while (!bus_if.cdb_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_op(input string name, input logic [1:0] op, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, input logic [TAG_W-1:0] tag,
                          input logic [XLEN-1:0] exp_data, input int exp_lat, input int gdly);
        int lat;
        accept(op, a, b, tag);
        check({name, "/busy"}, 64'(bus_if.div_exec_unit_busy), 64'd1);
        wait_result(lat);
        check({name, "/lat"}, 64'(lat), 64'(exp_lat));
        check({name, "/data"}, 64'(bus_if.cdb_data), 64'(exp_data));
        check({name, "/tag"}, 64'(bus_if.cdb_tag), 64'(tag));
        repeat (gdly) @(negedge clk);
        if (gdly > 0)
            check({name, "/hold"}, 64'(bus_if.cdb_data), 64'(exp_data));
        bus_if.cdb_grant = 1'b1;
        @(negedge clk);
        bus_if.cdb_grant = 1'b0;
        check({name, "/drop"}, {62'd0, bus_if.cdb_valid, bus_if.div_exec_unit_busy}, 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        bit seen;
        logic [XLEN:0] r;
        logic [1:0] op;
        logic [XLEN-1:0] a, b;

        bus_if.issue_valid   = 1'b0;
        bus_if.issue_op      = '0;
        bus_if.issue_rs_data = '0;
        bus_if.issue_rt_data = '0;
        bus_if.issue_rd_tag  = '0;
        bus_if.flush         = 1'b0;
        bus_if.cdb_grant     = 1'b0;

        vecs.push_back('{2'b01, 32'd100,        32'd7,          6'd5,  32'd14,         33});
        vecs.push_back('{2'b11, 32'd100,        32'd7,          6'd5,  32'd2,          33});
        vecs.push_back('{2'b00, 32'hFFFF_FFF9,  32'd2,          6'd11, 32'hFFFF_FFFD,  33});
        vecs.push_back('{2'b10, 32'hFFFF_FFF9,  32'd2,          6'd12, 32'hFFFF_FFFF,  33});
        vecs.push_back('{2'b00, 32'd7,          32'hFFFF_FFFE,  6'd13, 32'hFFFF_FFFD,  33});
        vecs.push_back('{2'b00, 32'h1234,       32'd0,          6'd20, 32'hFFFF_FFFF,  1});
        vecs.push_back('{2'b10, 32'h1234,       32'd0,          6'd21, 32'h1234,       1});
        vecs.push_back('{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  6'd30, 32'h8000_0000,  1});
        vecs.push_back('{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  6'd31, 32'd0,          1});
        vecs.push_back('{2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  6'd40, 32'd0,          33});
        vecs.push_back('{2'b11, 32'hFFFF_FFFF,  32'h1_0000,     6'd63, 32'hFFFF,       33});
        vecs.push_back('{2'b10, 32'h8000_0000,  32'd3,          6'd1,  32'hFFFF_FFFE,  33});

        repeat (3) @(negedge clk);
        check("rst/busy",   64'(bus_if.div_exec_unit_busy), 64'd0);
        check("rst/valid",  64'(bus_if.cdb_valid), 64'd0);
        check("rst/data",   64'(bus_if.cdb_data), 64'd0);
        check("rst/tag",    64'(bus_if.cdb_tag), 64'd0);
        check("rst/branch", {62'd0, bus_if.cdb_branch, bus_if.cdb_branch_taken}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag,
                   vecs[i].exp_data, vecs[i].exp_lat, 0);

        // Backpressure with an issue held across DONE and the grant edge.
        accept(2'b01, 32'd100, 32'd7, 6'd9);
        wait_result(lat);
        check("bp/lat", 64'(lat), 64'd33);
        bus_if.issue_op = 2'b01; bus_if.issue_rs_data = 32'd50; bus_if.issue_rt_data = 32'd5;
        bus_if.issue_rd_tag = 6'd3; bus_if.issue_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp/hold", {bus_if.cdb_valid, bus_if.div_exec_unit_busy, 6'(bus_if.cdb_tag),
                              bus_if.cdb_data}, {1'b1, 1'b1, 6'd9, 32'd14});
        end
        bus_if.cdb_grant = 1'b1;
        @(negedge clk);
        bus_if.cdb_grant = 1'b0;
        check("bp/idle", {62'd0, bus_if.cdb_valid, bus_if.div_exec_unit_busy}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        bus_if.issue_valid = 1'b0;
        check("bp/next_busy", 64'(bus_if.div_exec_unit_busy), 64'd1);
        wait_result(lat);
        check("bp/next_lat", 64'(lat), 64'd33);
        check("bp/next_data", {26'd0, 6'(bus_if.cdb_tag), bus_if.cdb_data}, {26'd0, 6'd3, 32'd10});
        bus_if.cdb_grant = 1'b1;
        @(negedge clk);
        bus_if.cdb_grant = 1'b0;

        // Flush at CALC cycle 10 with a colliding issue and grant.
        accept(2'b01, 32'd100, 32'd7, 6'd4);
        repeat (9) @(negedge clk);
        bus_if.flush = 1'b1; bus_if.issue_valid = 1'b1; bus_if.cdb_grant = 1'b1;
        @(negedge clk);
        bus_if.flush = 1'b0; bus_if.issue_valid = 1'b0; bus_if.cdb_grant = 1'b0;
        check("flush/idle", {62'd0, bus_if.cdb_valid, bus_if.div_exec_unit_busy}, 64'd0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus_if.cdb_valid || bus_if.div_exec_unit_busy) seen = 1'b1;
        end
        check("flush/quiet", 64'(seen), 64'd0);

        // Asynchronous reset at CALC cycle 20.
        accept(2'b00, 32'hFFFF_FFF9, 32'd2, 6'd7);
        repeat (19) @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst/outs", {bus_if.cdb_valid, bus_if.div_exec_unit_busy, 6'(bus_if.cdb_tag),
                            bus_if.cdb_data}, 40'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op("arst/divu9_3", 2'b01, 32'd9, 32'd3, 6'd2, 32'd3, 33, 0);

        // Randomized operations against the arithmetic reference.
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 5))
                0: b = '0;
                1: begin a = MIN_VAL; b = '1; end
                2: b = XLEN'($urandom_range(1, 15));
                3: b = '1;
                default: ;
            endcase
            r = ref_div(op, a, b);
            run_op($sformatf("rnd%0d", i), op, a, b, TAG_W'($urandom), r[XLEN-1:0],
                   r[XLEN] ? 1 : XLEN + 1, int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
